// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the PC sequencer: FSM state encoding,
//               default reset vector and the sequential PC increment.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Sequencer FSM state encoding (explicit 3-bit width)
    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_TRAP  = 3'd4;

    // Default address of the first instruction fetched after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Distance between consecutive instructions
    localparam logic [31:0] PC_INC = 32'd4;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational control-transfer target generator.
//               jalr=1 : target = (rs1_data + imm) with bit 0 cleared
//               jalr=0 : target = pc + imm   (JAL and conditional branches)
//               misaligned flags a target that is not word aligned in bit 1.
// Ports       : pc, imm, rs1_data (in, 32)  operands
//               jalr             (in, 1)   selects register-relative target
//               target           (out, 32) computed target address
//               misaligned       (out, 1)  target[1] is set
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        jalr,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] w_jalr_sum;
    logic [31:0] w_rel_sum;

    // Both sums wrap modulo 2^32 by construction of the 32-bit add
    assign w_jalr_sum = rs1_data + imm;
    assign w_rel_sum  = pc + imm;

    assign target     = jalr ? {w_jalr_sum[31:1], 1'b0} : w_rel_sum;
    // Bit 0 is never examined: JALR clears it, and PC-relative immediates are even.
    assign misaligned = target[1];

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer. Fetches the word at pc, waits for
//               the datapath to retire it, then selects the next pc by
//               priority halt_req > jalr > jump > branch_confirm > pc+4.
//               Misaligned control-transfer targets and halts are absorbing.
// Ports       : clk, rst        (in)  clock, synchronous active-high reset
//               imem_ready      (in)  instruction word for pc is available
//               stall           (in)  datapath cannot retire this cycle
//               branch_confirm, jump, jalr, halt_req (in) execute controls
//               imm, rs1_data   (in, 32) target operands
//               pc, pc_plus4    (out, 32) current pc and its link value
//               imem_req        (out) fetch request for pc
//               instr_valid     (out) fetched instruction is in execute
//               redirect        (out) one-cycle pulse after a taken transfer
//               trap_misaligned, trap_addr (out) sticky misaligned trap
//               halted          (out) sticky halt
//               instret         (out, INSTRET_W) retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_ready,
    input  logic                 stall,
    input  logic                 branch_confirm,
    input  logic                 jump,
    input  logic                 jalr,
    input  logic                 halt_req,
    input  logic [31:0]          imm,
    input  logic [31:0]          rs1_data,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 imem_req,
    output logic                 instr_valid,
    output logic                 redirect,
    output logic                 trap_misaligned,
    output logic [31:0]          trap_addr,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [INSTRET_W-1:0] C_INSTRET_ONE = INSTRET_W'(1);

    logic [2:0]           state_q,     state_d;
    logic [31:0]          pc_q,        pc_d;
    logic [31:0]          trap_addr_q, trap_addr_d;
    logic [INSTRET_W-1:0] instret_q,   instret_d;
    logic                 redirect_q,  redirect_d;

    logic [31:0]          w_target;
    logic                 w_misaligned;
    logic                 w_take_target;
    logic [31:0]          w_pc_plus4;

    pc_target_calc u_target_calc (
        .pc         (pc_q),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .jalr       (jalr),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    assign w_pc_plus4 = pc_q + PC_INC;

    // jump and branch_confirm share the pc+imm target, so only the jalr
    // selection inside the calculator needs to honour priority.
    assign w_take_target = jalr | jump | branch_confirm;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_addr_d = trap_addr_q;
        instret_d   = instret_q;
        redirect_d  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (halt_req) begin
                        // The halting instruction itself counts as retired
                        state_d   = ST_HALT;
                        instret_d = instret_q + C_INSTRET_ONE;
                    end else if (w_take_target) begin
                        if (w_misaligned) begin
                            state_d     = ST_TRAP;
                            trap_addr_d = w_target;
                        end else begin
                            state_d    = ST_FETCH;
                            pc_d       = w_target;
                            instret_d  = instret_q + C_INSTRET_ONE;
                            redirect_d = 1'b1;
                        end
                    end else begin
                        state_d   = ST_FETCH;
                        pc_d      = w_pc_plus4;
                        instret_d = instret_q + C_INSTRET_ONE;
                    end
                end
            end
            ST_HALT, ST_TRAP: begin
                state_d = state_q;
            end
            default: begin
                // Unreachable encodings fall back to a clean restart
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            trap_addr_q <= 32'h0000_0000;
            instret_q   <= '0;
            redirect_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_addr_q <= trap_addr_d;
            instret_q   <= instret_d;
            redirect_q  <= redirect_d;
        end
    end

    assign pc              = pc_q;
    assign pc_plus4        = w_pc_plus4;
    assign imem_req        = (state_q == ST_FETCH);
    assign instr_valid     = (state_q == ST_EXEC);
    assign redirect        = redirect_q;
    assign trap_misaligned = (state_q == ST_TRAP);
    assign trap_addr       = trap_addr_q;
    assign halted          = (state_q == ST_HALT);
    assign instret         = instret_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed scenarios with
//               constant expectations plus a randomized run compared against
//               a transaction-level reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] C_RST_PC = 32'h0000_0000;

    // Reference-model modes
    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;
    localparam int M_TRAP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        stall;
    logic        branch_confirm;
    logic        jump;
    logic        jalr;
    logic        halt_req;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        instr_valid;
    logic        redirect;
    logic        trap_misaligned;
    logic [31:0] trap_addr;
    logic        halted;
    logic [63:0] instret;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .RESET_PC  (C_RST_PC),
        .INSTRET_W (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_ready      (imem_ready),
        .stall           (stall),
        .branch_confirm  (branch_confirm),
        .jump            (jump),
        .jalr            (jalr),
        .halt_req        (halt_req),
        .imm             (imm),
        .rs1_data        (rs1_data),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .imem_req        (imem_req),
        .instr_valid     (instr_valid),
        .redirect        (redirect),
        .trap_misaligned (trap_misaligned),
        .trap_addr       (trap_addr),
        .halted          (halted),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        imem_ready     = 1'b0;
        stall          = 1'b0;
        branch_confirm = 1'b0;
        jump           = 1'b0;
        jalr           = 1'b0;
        halt_req       = 1'b0;
        imm            = 32'h0;
        rs1_data       = 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in BOOT with rst low.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Advance until the fetched instruction is in execute, bounded.
    task automatic goto_exec();
        imem_ready = 1'b1;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) cycle();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL goto_exec_timeout: instr_valid=%b required 1", instr_valid);
        end
    endtask

    task automatic test_reset();
        // Every control asserted alongside rst: reset must win
        rst = 1'b1; imem_ready = 1'b1; jump = 1'b1; halt_req = 1'b1;
        branch_confirm = 1'b1; jalr = 1'b1; imm = 32'h6; rs1_data = 32'h7;
        cycle();
        cycle();
        checks++; if (pc !== C_RST_PC) begin errors++; $display("FAIL reset_pc: got %h required %h", pc, C_RST_PC); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h required %h", pc_plus4, 32'h4); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d required 0", instret); end
        checks++; if (trap_addr !== 32'h0) begin errors++; $display("FAIL reset_trap_addr: got %h required 0", trap_addr); end
        checks++; if ({imem_req, instr_valid, redirect, trap_misaligned, halted} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b required 00000", {imem_req, instr_valid, redirect, trap_misaligned, halted}); end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_boot_sequential();
        clear_inputs();
        imem_ready = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %b required 0", imem_req); end
        cycle();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_then_fetch: got %b required 1", imem_req); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h required 0", pc); end
        cycle();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL boot_exec: got %b required 1", instr_valid); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL boot_instret0: got %0d required 0", instret); end
        cycle();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc: got %h required 4", pc); end
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL seq_instret: got %0d required 1", instret); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL seq_no_redirect: got %b required 0", redirect); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_refetch: got %b required 1", imem_req); end
    endtask

    task automatic test_branch_jalr_wrap();
        do_reset();
        goto_exec();
        jump = 1'b1; imm = 32'h100;
        cycle();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_pc: got %h required 100", pc); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jump_redirect: got %b required 1", redirect); end
        jump = 1'b0;
        cycle();
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL redirect_one_cycle: got %b required 0", redirect); end
        branch_confirm = 1'b1; imm = 32'hFFFF_FFF0;
        cycle();
        checks++; if (pc !== 32'hF0) begin errors++; $display("FAIL branch_back_pc: got %h required f0", pc); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL branch_redirect: got %b required 1", redirect); end
        branch_confirm = 1'b0;
        cycle();
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL branch_redirect_drop: got %b required 0", redirect); end
        // jalr outranks branch_confirm, and bit 0 of the sum is cleared
        branch_confirm = 1'b1; jalr = 1'b1; rs1_data = 32'h201; imm = 32'h0;
        cycle();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jalr_priority_pc: got %h required 200", pc); end
        checks++; if (instret !== 64'd3) begin errors++; $display("FAIL jalr_instret: got %0d required 3", instret); end
        clear_inputs();
        imem_ready = 1'b1;
        cycle();
        jump = 1'b1; imm = 32'hFFFF_FDFC;
        cycle();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_pc: got %h required fffffffc", pc); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4: got %h required 0", pc_plus4); end
        jump = 1'b0;
        cycle();
        cycle();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_seq_pc: got %h required 0", pc); end
        checks++; if (instret !== 64'd5) begin errors++; $display("FAIL wrap_instret: got %0d required 5", instret); end
        clear_inputs();
    endtask

    task automatic test_trap();
        do_reset();
        goto_exec();
        jump = 1'b1; imm = 32'h100;
        cycle();
        jump = 1'b0;
        goto_exec();
        jump = 1'b1; imm = 32'h6;
        cycle();
        checks++; if (trap_misaligned !== 1'b1) begin errors++; $display("FAIL trap_flag: got %b required 1", trap_misaligned); end
        checks++; if (trap_addr !== 32'h106) begin errors++; $display("FAIL trap_addr: got %h required 106", trap_addr); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_pc_held: got %h required 100", pc); end
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL trap_instret: got %0d required 1", instret); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL trap_no_redirect: got %b required 0", redirect); end
        jump = 1'b0; imem_ready = 1'b1; branch_confirm = 1'b1; halt_req = 1'b1; imm = 32'h40;
        repeat (4) cycle();
        checks++; if ({trap_misaligned, halted, imem_req, instr_valid} !== 4'b1000)
            begin errors++; $display("FAIL trap_absorbing: got %b required 1000", {trap_misaligned, halted, imem_req, instr_valid}); end
        checks++; if (pc !== 32'h100 || instret !== 64'd1) begin errors++; $display("FAIL trap_frozen: pc=%h instret=%0d required 100/1", pc, instret); end
        clear_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        goto_exec();
        stall = 1'b1; branch_confirm = 1'b1; imm = 32'h40;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (pc !== 32'h0 || instret !== 64'd0 || instr_valid !== 1'b1 || redirect !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: pc=%h instret=%0d valid=%b redirect=%b required 0/0/1/0", i, pc, instret, instr_valid, redirect);
            end
        end
        stall = 1'b0;
        cycle();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_release_pc: got %h required 40", pc); end
        checks++; if (redirect !== 1'b1 || instret !== 64'd1) begin errors++; $display("FAIL stall_release: redirect=%b instret=%0d required 1/1", redirect, instret); end
        clear_inputs();
    endtask

    task automatic test_fetch_reset();
        do_reset();
        goto_exec();
        cycle();
        imem_ready = 1'b0;
        repeat (5) cycle();
        checks++; if (imem_req !== 1'b1 || pc !== 32'h4 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL fetch_wait: req=%b pc=%h valid=%b required 1/4/0", imem_req, pc, instr_valid); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (pc !== C_RST_PC || instret !== 64'd0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL fetch_reset: pc=%h instret=%0d req=%b required 0/0/0", pc, instret, imem_req); end
        cycle();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_reset_boot_len: got %b required 1", imem_req); end
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        goto_exec();
        cycle();
        goto_exec();
        halt_req = 1'b1; jump = 1'b1; imm = 32'h80;
        cycle();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b required 1", halted); end
        checks++; if (pc !== 32'h4 || instret !== 64'd2) begin errors++; $display("FAIL halt_state: pc=%h instret=%0d required 4/2", pc, instret); end
        checks++; if (redirect !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_quiet: redirect=%b valid=%b required 0/0", redirect, instr_valid); end
        halt_req = 1'b0; jalr = 1'b1; rs1_data = 32'h1000; imem_ready = 1'b1;
        repeat (4) cycle();
        checks++; if (halted !== 1'b1 || pc !== 32'h4 || instret !== 64'd2 || trap_misaligned !== 1'b0)
            begin errors++; $display("FAIL halt_absorbing: halted=%b pc=%h instret=%0d trap=%b required 1/4/2/0", halted, pc, instret, trap_misaligned); end
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit_rst: got %b required 0", halted); end
    endtask

    task automatic test_random(input int n);
        int          m_mode;
        logic [31:0] m_pc;
        logic [31:0] m_taddr;
        logic [63:0] m_inst;
        logic        m_red;
        logic [31:0] t;
        logic [31:0] r;
        logic        seq;
        m_mode = M_BOOT; m_pc = C_RST_PC; m_taddr = 32'h0; m_inst = 64'd0; m_red = 1'b0;
        for (int i = 0; i < n; i++) begin
            rst            = (i == 0) || ($urandom_range(49) == 0);
            imem_ready     = ($urandom_range(3) != 0);
            stall          = ($urandom_range(3) == 0);
            halt_req       = ($urandom_range(40) == 0);
            jalr           = ($urandom_range(5) == 0);
            jump           = ($urandom_range(5) == 0);
            branch_confirm = ($urandom_range(3) == 0);
            r = $urandom;
            imm = ($urandom_range(7) != 0) ? (r & 32'hFFFF_FFFC) : r;
            r = $urandom;
            rs1_data = ($urandom_range(7) != 0) ? (r & 32'hFFFF_FFFC) : r;

            // Reference model: one retire-level step per clock
            if (rst) begin
                m_mode = M_BOOT; m_pc = C_RST_PC; m_inst = 64'd0; m_taddr = 32'h0; m_red = 1'b0;
            end else begin
                m_red = 1'b0;
                if (m_mode == M_BOOT) m_mode = M_FETCH;
                else if (m_mode == M_FETCH) begin
                    if (imem_ready) m_mode = M_EXEC;
                end else if (m_mode == M_EXEC && !stall) begin
                    if (halt_req) begin
                        m_mode = M_HALT;
                        m_inst = m_inst + 64'd1;
                    end else begin
                        seq = !(jalr || jump || branch_confirm);
                        if (jalr)     t = (rs1_data + imm) & 32'hFFFF_FFFE;
                        else if (seq) t = m_pc + 32'd4;
                        else          t = m_pc + imm;
                        if (!seq && t[1]) begin
                            m_mode = M_TRAP; m_taddr = t;
                        end else begin
                            m_pc = t; m_inst = m_inst + 64'd1; m_red = !seq; m_mode = M_FETCH;
                        end
                    end
                end
            end
            cycle();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h required %h", i, pc, m_pc); end
            checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc_plus4[%0d]: got %h required %h", i, pc_plus4, m_pc + 32'd4); end
            checks++; if (instret !== m_inst) begin errors++; $display("FAIL rnd_instret[%0d]: got %0d required %0d", i, instret, m_inst); end
            checks++; if (redirect !== m_red) begin errors++; $display("FAIL rnd_redirect[%0d]: got %b required %b", i, redirect, m_red); end
            checks++; if (trap_addr !== m_taddr) begin errors++; $display("FAIL rnd_trap_addr[%0d]: got %h required %h", i, trap_addr, m_taddr); end
            checks++;
            if (imem_req !== (m_mode == M_FETCH) || instr_valid !== (m_mode == M_EXEC) ||
                halted !== (m_mode == M_HALT) || trap_misaligned !== (m_mode == M_TRAP)) begin
                errors++;
                $display("FAIL rnd_mode[%0d]: req/valid/halt/trap=%b%b%b%b model mode %0d", i, imem_req, instr_valid, halted, trap_misaligned, m_mode);
            end
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_boot_sequential();
        test_branch_jalr_wrap();
        test_trap();
        test_stall();
        test_fetch_reset();
        test_halt();
        test_random(600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
